// File: rtl/qam_pkg.sv
// Shared constants, state type and the Gray slicer for the
// coherent 16-QAM demodulator.
package qam_pkg;

    localparam int SPS_DEF      = 32;
    localparam int LOG2_SPS_DEF = 5;

    localparam logic [1:0] G_NEG3 = 2'b00;
    localparam logic [1:0] G_NEG1 = 2'b01;
    localparam logic [1:0] G_POS1 = 2'b11;
    localparam logic [1:0] G_POS3 = 2'b10;

    typedef enum logic {IDLE, RUN} state_e;

    function automatic int acc_width(input int log2_sps);
        return 16 + log2_sps;
    endfunction

    // Outer/inner decision on one axis of the integrated symbol.
    function automatic logic [1:0] slice(
        input logic signed [31:0] acc,
        input int                 thr
    );
        if (acc >= thr) begin
            return G_POS3;
        end else if (acc >= 0) begin
            return G_POS1;
        end else if (acc >= -thr) begin
            return G_NEG1;
        end else begin
            return G_NEG3;
        end
    endfunction

endpackage

// File: rtl/qam_ref_lut.sv
// Local cos/sin carrier references, one period over SPS phases,
// derived from a 64-phase quarter-wave table.
module qam_ref_lut
    import qam_pkg::*;
#(
    parameter int SPS = SPS_DEF
) (
    input  logic [$clog2(SPS)-1:0] k,
    output logic signed [7:0]      cos_o,
    output logic signed [7:0]      sin_o
);

    localparam int SHIFT = 6 - $clog2(SPS);

    logic [5:0] ph_sin;
    logic [5:0] ph_cos;

    // round(127*sin(2*pi*i/64)) for i = 0..16
    function automatic logic signed [7:0] qtab(input logic [4:0] i);
        case (i)
            5'd0:    return 8'sd0;
            5'd1:    return 8'sd12;
            5'd2:    return 8'sd25;
            5'd3:    return 8'sd37;
            5'd4:    return 8'sd49;
            5'd5:    return 8'sd60;
            5'd6:    return 8'sd71;
            5'd7:    return 8'sd81;
            5'd8:    return 8'sd90;
            5'd9:    return 8'sd98;
            5'd10:   return 8'sd106;
            5'd11:   return 8'sd112;
            5'd12:   return 8'sd117;
            5'd13:   return 8'sd122;
            5'd14:   return 8'sd125;
            5'd15:   return 8'sd126;
            default: return 8'sd127;
        endcase
    endfunction

    function automatic logic signed [7:0] fsin(input logic [5:0] p);
        logic [4:0] r;
        r = {1'b0, p[3:0]};
        case (p[5:4])
            2'd0:    return qtab(r);
            2'd1:    return qtab(5'd16 - r);
            2'd2:    return -qtab(r);
            default: return -qtab(5'd16 - r);
        endcase
    endfunction

    always_comb begin
        ph_sin = 6'(k) << SHIFT;
        ph_cos = ph_sin + 6'd16;
        sin_o  = fsin(ph_sin);
        cos_o  = fsin(ph_cos);
    end

endmodule

// File: rtl/qam16_coherent_demod.sv
// Integrate-and-dump coherent 16-QAM demodulator with sync-driven
// symbol alignment and Gray-coded slicing.
module qam16_coherent_demod
    import qam_pkg::*;
#(
    parameter int SPS      = SPS_DEF,
    parameter int LOG2_SPS = LOG2_SPS_DEF,
    parameter int ACC_W    = acc_width(LOG2_SPS),
    parameter int THRESH   = 113792
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic signed [7:0]       data_in,
    input  logic                    in_valid,
    input  logic                    sync,
    output logic [3:0]              sym_out,
    output logic                    sym_valid,
    output logic signed [ACC_W-1:0] i_acc,
    output logic signed [ACC_W-1:0] q_acc,
    output logic                    locked,
    output logic                    slip
);

    state_e                  state_q, state_d;
    logic [LOG2_SPS-1:0]     k_q, k_d, k_idx;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] i_acc_q, i_acc_d;
    logic signed [ACC_W-1:0] q_acc_q, q_acc_d;
    logic [3:0]              sym_out_q, sym_out_d;
    logic                    sym_valid_q, sym_valid_d;
    logic                    locked_q, locked_d;
    logic                    slip_q, slip_d;

    logic signed [7:0]       cos_r, sin_r;
    logic signed [15:0]      prod_i, prod_q;
    logic signed [ACC_W-1:0] ext_i, ext_q, sum_i, sum_q;
    logic signed [31:0]      wide_i, wide_q;

    // A synced sample is always phase 0, whatever k currently holds.
    assign k_idx = (in_valid && sync) ? '0 : k_q;

    qam_ref_lut #(.SPS(SPS)) u_lut (
        .k     (k_idx),
        .cos_o (cos_r),
        .sin_o (sin_r)
    );

    always_comb begin
        prod_i = data_in * cos_r;
        prod_q = data_in * sin_r;
        ext_i  = {{(ACC_W-16){prod_i[15]}}, prod_i};
        ext_q  = {{(ACC_W-16){prod_q[15]}}, prod_q};
        sum_i  = acc_i_q + ext_i;
        sum_q  = acc_q_q + ext_q;
        wide_i = {{(32-ACC_W){sum_i[ACC_W-1]}}, sum_i};
        wide_q = {{(32-ACC_W){sum_q[ACC_W-1]}}, sum_q};

        state_d     = state_q;
        k_d         = k_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        i_acc_d     = i_acc_q;
        q_acc_d     = q_acc_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = 1'b0;
        locked_d    = locked_q;
        slip_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && sync) begin
                    acc_i_d  = ext_i;
                    acc_q_d  = ext_q;
                    k_d      = LOG2_SPS'(1);
                    locked_d = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (in_valid && sync) begin
                    acc_i_d = ext_i;
                    acc_q_d = ext_q;
                    k_d     = LOG2_SPS'(1);
                    slip_d  = (k_q != '0);
                end else if (in_valid) begin
                    if (k_q == LOG2_SPS'(SPS-1)) begin
                        sym_valid_d = 1'b1;
                        i_acc_d     = sum_i;
                        q_acc_d     = sum_q;
                        sym_out_d   = {slice(wide_i, THRESH),
                                       slice(wide_q, THRESH)};
                        acc_i_d     = '0;
                        acc_q_d     = '0;
                        k_d         = '0;
                    end else begin
                        acc_i_d = sum_i;
                        acc_q_d = sum_q;
                        k_d     = k_q + LOG2_SPS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            i_acc_q     <= '0;
            q_acc_q     <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            slip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            i_acc_q     <= i_acc_d;
            q_acc_q     <= q_acc_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            locked_q    <= locked_d;
            slip_q      <= slip_d;
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign i_acc     = i_acc_q;
    assign q_acc     = q_acc_q;
    assign locked    = locked_q;
    assign slip      = slip_q;

endmodule

// File: tb/tb_qam16_coherent_demod.sv
// Directed self-checking bench for qam16_coherent_demod.
// Symbols are synthesised from an independent carrier table.
module tb_qam16_coherent_demod;

    localparam int ACC_W  = 21;
    localparam int THRESH = 113792;

    logic                    clk;
    logic                    rst_n;
    logic signed [7:0]       data_in;
    logic                    in_valid;
    logic                    sync;
    logic [3:0]              sym_out;
    logic                    sym_valid;
    logic signed [ACC_W-1:0] i_acc;
    logic signed [ACC_W-1:0] q_acc;
    logic                    locked;
    logic                    slip;

    int nchk;
    int nerr;
    int exp_i;
    int exp_q;
    int sv_early;
    int slip_first;
    int slip_later;
    int sv_idle;

    qam16_coherent_demod dut (
        .Clk       (clk),
        .reset     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .sync      (sync),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .i_acc     (i_acc),
        .q_acc     (q_acc),
        .locked    (locked),
        .slip      (slip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bsin(input int k);
        int q8[0:8] = '{0, 25, 49, 71, 90, 106, 117, 125, 127};
        int p;
        int r;
        p = k % 32;
        r = p % 8;
        case (p / 8)
            0:       return q8[r];
            1:       return q8[8-r];
            2:       return -q8[r];
            default: return -q8[8-r];
        endcase
    endfunction

    function automatic int bcos(input int k);
        return bsin(k + 8);
    endfunction

    function automatic int bsample(input int ai, input int aq, input int k);
        int v;
        v = ai * bcos(k) + aq * bsin(k);
        return v >>> 7;
    endfunction

    function automatic logic [1:0] bslice(input int a);
        if (a >= THRESH) return 2'b10;
        if (a >= 0) return 2'b11;
        if (a >= -THRESH) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends n samples of symbol (ai,aq) starting at phase 0.
    task automatic send_symbol(input int ai, input int aq,
                               input bit sync0, input bit gap,
                               input int n);
        int s;
        exp_i      = 0;
        exp_q      = 0;
        sv_early   = 0;
        slip_first = 0;
        slip_later = 0;
        for (int k = 0; k < n; k++) begin
            s        = bsample(ai, aq, k);
            data_in  = 8'(s);
            in_valid = 1'b1;
            sync     = sync0 && (k == 0);
            step();
            exp_i += s * bcos(k);
            exp_q += s * bsin(k);
            if (k == 0) slip_first = int'(slip);
            else slip_later += int'(slip);
            if (k < n - 1) sv_early += int'(sym_valid);
            if (gap && (k % 5 == 4) && (k < n - 1)) begin
                for (int g = 0; g < 3; g++) begin
                    in_valid = 1'b0;
                    data_in  = 8'($urandom);
                    sync     = 1'($urandom);
                    step();
                    sv_early   += int'(sym_valid);
                    slip_later += int'(slip);
                end
            end
        end
        in_valid = 1'b0;
        sync     = 1'b0;
    endtask

    task automatic chk_symbol(input string tag);
        chk({tag, "_valid"}, 32'(sym_valid), 1);
        chk({tag, "_early"}, sv_early, 0);
        chk({tag, "_slip"}, 32'(slip), 0);
        chk({tag, "_i"}, i_acc, exp_i);
        chk({tag, "_q"}, q_acc, exp_q);
        chk({tag, "_sym"}, 32'(sym_out),
            32'({bslice(exp_i), bslice(exp_q)}));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_sym"}, 32'(sym_out), 0);
        chk({tag, "_sv"}, 32'(sym_valid), 0);
        chk({tag, "_i"}, i_acc, 0);
        chk({tag, "_q"}, q_acc, 0);
        chk({tag, "_lock"}, 32'(locked), 0);
        chk({tag, "_slip"}, 32'(slip), 0);
    endtask

    initial begin
        int amps[4] = '{84, 28, -28, -84};
        nchk     = 0;
        nerr     = 0;
        rst_n    = 1'b0;
        data_in  = '0;
        in_valid = 1'b0;
        sync     = 1'b0;

        for (int c = 0; c < 3; c++) begin
            data_in  = 8'($urandom);
            in_valid = 1'($urandom);
            sync     = 1'($urandom);
            step();
        end
        chk_cleared("reset");

        rst_n   = 1'b1;
        sync    = 1'b0;
        sv_idle = 0;
        for (int c = 0; c < 200; c++) begin
            data_in  = 8'($urandom);
            in_valid = 1'($urandom);
            step();
            sv_idle += int'(sym_valid);
        end
        chk("idle_no_sv", sv_idle, 0);
        chk("idle_unlocked", 32'(locked), 0);

        send_symbol(84, 84, 1'b1, 1'b0, 32);
        chk_symbol("single");
        chk("single_locked", 32'(locked), 1);
        chk("single_sym_lit", 32'(sym_out), 32'(4'b1010));
        chk("single_i_approx",
            32'((i_acc > 167274) && (i_acc < 174102)), 1);
        step();
        chk("single_pulse_drop", 32'(sym_valid), 0);

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                send_symbol(amps[a], amps[b], (a == 0) && (b == 0),
                            1'b0, 32);
                chk_symbol($sformatf("sweep_%0d_%0d", amps[a], amps[b]));
                chk("sweep_noslip", slip_first + slip_later, 0);
                if (amps[a] == 28 && amps[b] == -84) begin
                    chk("sweep_28m84_lit", 32'(sym_out), 32'(4'b1100));
                end
            end
        end

        send_symbol(-28, 28, 1'b0, 1'b1, 32);
        chk_symbol("gapped");
        chk("gapped_lit", 32'(sym_out), 32'(4'b0111));
        chk("gapped_noslip", slip_first + slip_later, 0);

        send_symbol(28, 28, 1'b0, 1'b0, 13);
        chk("abort_no_sv", sv_early + int'(sym_valid), 0);
        send_symbol(-84, -28, 1'b1, 1'b0, 32);
        chk("resync_slip", slip_first, 1);
        chk("resync_slip_once", slip_later, 0);
        chk_symbol("resync");

        send_symbol(84, -28, 1'b0, 1'b0, 20);
        chk("pre_rst_locked", 32'(locked), 1);
        rst_n = 1'b0;
        #1;
        chk_cleared("async_rst");
        for (int c = 0; c < 2; c++) begin
            data_in  = 8'($urandom);
            in_valid = 1'b1;
            sync     = 1'b1;
            step();
        end
        chk_cleared("rst_hold");
        rst_n = 1'b1;
        sync  = 1'b0;

        send_symbol(84, 84, 1'b0, 1'b0, 32);
        chk("post_rst_nosync_sv", sv_early + int'(sym_valid), 0);
        chk("post_rst_nosync_lock", 32'(locked), 0);
        send_symbol(-84, 28, 1'b1, 1'b0, 32);
        chk_symbol("post_rst");
        chk("post_rst_lock", 32'(locked), 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
